dca_matrix_tile_sequencer: RTL and testbench

//  Drives the matrix splitter through every block of one matrix and issues one LSU load/store request per block.

---
 rtl/dca_matrix_tile_sequencer_pkg.sv | 37 +++
 rtl/dca_outstanding_counter.sv | 58 +++++
 rtl/dca_matrix_tile_sequencer.sv | 146 ++++++++++++++
 tb/tb_dca_matrix_tile_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_tile_sequencer_pkg.sv
// rtl/dca_matrix_tile_sequencer_pkg.sv - shared types and widths for the matrix tile sequencer
// Purpose: matrix descriptor layout, LSU opcode width, sequencer state encoding
//          and the matrix dimension helpers used to size the splitter tile.
// Ports: none (package).
package dca_matrix_tile_sequencer_pkg;

    localparam int BW_DCA_MATRIX_ADDR     = 16;
    localparam int BW_DCA_MATRIX_DIM      = 8;
    localparam int BW_DCA_MATRIX_INFO     = BW_DCA_MATRIX_ADDR + 2 * BW_DCA_MATRIX_DIM;
    localparam int BW_DCA_MATRIX_LSU_INST = 4;

    // Descriptor used both for the whole matrix and for each splitter block.
    typedef struct packed {
        logic [BW_DCA_MATRIX_ADDR-1:0] addr;
        logic [BW_DCA_MATRIX_DIM-1:0]  num_row_m1;
        logic [BW_DCA_MATRIX_DIM-1:0]  num_col_m1;
    } dca_matrix_info_t;

    typedef enum logic [2:0] {
        DCA_TSEQ_IDLE    = 3'd0,
        DCA_TSEQ_INIT    = 3'd1,
        DCA_TSEQ_ISSUE   = 3'd2,
        DCA_TSEQ_ADVANCE = 3'd3,
        DCA_TSEQ_DRAIN   = 3'd4,
        DCA_TSEQ_DONE    = 3'd5
    } dca_tseq_state_e;

    // Splitter tiles are square: one tile size gives both block dimensions.
    function automatic int dca_matrix_num_row(input int matrix_size);
        return matrix_size;
    endfunction

    function automatic int dca_matrix_num_col(input int matrix_size);
        return matrix_size;
    endfunction

endpackage

// File: rtl/dca_outstanding_counter.sv
// rtl/dca_outstanding_counter.sv - saturating up/down counter of in-flight LSU requests
// Purpose: tracks requests accepted by the LSU but not yet completed.
// Ports: clk, rstnn (async active-low), clear (sync zero), enable (freeze when low),
//        inc (request accepted), dec (request completed),
//        full (count == MAX_COUNT), empty (count == 0), empty_next (count will be 0 next cycle).
module dca_outstanding_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rstnn,
    input  logic clear,
    input  logic enable,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic empty_next
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             dec_ok;

    always_comb begin
        // A completion with nothing in flight is dropped so the count never wraps.
        dec_ok  = dec && (count_q != '0);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (inc && !dec_ok && !full) begin
                count_d = count_q + CNT_W'(1);
            end else if (dec_ok && !inc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    assign full       = (count_q == CNT_W'(MAX_COUNT));
    assign empty      = (count_q == '0);
    assign empty_next = (count_d == '0);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always @(posedge clk) begin
        if (rstnn && enable && !clear) begin
            assert (!(dec && empty));
        end
    end

endmodule

// File: rtl/dca_matrix_tile_sequencer.sv
// rtl/dca_matrix_tile_sequencer.sv - walks the splitter over one matrix, one LSU request per block
// Purpose: accepts a matrix command, steps the splitter (init/iterate/go_next_base),
//          forwards each block to the LSU with a cap on in-flight requests, and
//          pulses done once the final LSU completion has arrived.
// Ports: clk, rstnn (async active-low), clear (sync abort), enable (global freeze);
//        cmd_* : matrix command handshake and payload;
//        spl_* : latched descriptor/order and strobes to the splitter, status/block back;
//        lsu_* : block request handshake, opcode, block info, completion pulse;
//        busy (not idle), done (one-cycle completion pulse).
module dca_matrix_tile_sequencer
    import dca_matrix_tile_sequencer_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int BW_INST          = BW_DCA_MATRIX_LSU_INST
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [BW_DCA_MATRIX_INFO-1:0] cmd_matrix_info,
    input  logic                          cmd_is_col_first,
    input  logic [BW_INST-1:0]            cmd_inst,
    output logic [BW_DCA_MATRIX_INFO-1:0] spl_matrix_info,
    output logic                          spl_is_col_first,
    output logic                          spl_init,
    output logic                          spl_iterate,
    output logic                          spl_go_next_base,
    input  logic                          spl_is_last_x,
    input  logic                          spl_is_last_y,
    input  logic                          spl_is_last_element,
    input  logic [BW_DCA_MATRIX_INFO-1:0] spl_block_info,
    output logic                          lsu_req_valid,
    input  logic                          lsu_req_ready,
    output logic [BW_INST-1:0]            lsu_req_inst,
    output logic [BW_DCA_MATRIX_INFO-1:0] lsu_req_info,
    input  logic                          lsu_done,
    output logic                          busy,
    output logic                          done
);

    localparam int MATRIX_NUM_ROW = dca_matrix_num_row(MATRIX_SIZE_PARA);
    localparam int MATRIX_NUM_COL = dca_matrix_num_col(MATRIX_SIZE_PARA);

    dca_tseq_state_e               state_q, state_d;
    logic [BW_DCA_MATRIX_INFO-1:0] info_q, info_d;
    logic                          col_first_q, col_first_d;
    logic [BW_INST-1:0]            inst_q, inst_d;

    logic cnt_full;
    logic cnt_empty;
    logic cnt_empty_next;
    logic req_fire;

    dca_outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk        (clk),
        .rstnn      (rstnn),
        .clear      (clear),
        .enable     (enable),
        .inc        (req_fire),
        .dec        (lsu_done),
        .full       (cnt_full),
        .empty      (cnt_empty),
        .empty_next (cnt_empty_next)
    );

    // Level outputs hold through enable=0; strobes drop so the splitter and
    // the control FSM never see an event while the block is frozen.
    assign cmd_ready        = (state_q == DCA_TSEQ_IDLE);
    assign busy             = (state_q != DCA_TSEQ_IDLE);
    assign lsu_req_valid    = (state_q == DCA_TSEQ_ISSUE) && !cnt_full;
    assign lsu_req_inst     = inst_q;
    assign lsu_req_info     = spl_block_info;
    assign spl_matrix_info  = info_q;
    assign spl_is_col_first = col_first_q;
    assign spl_init         = enable && !clear && (state_q == DCA_TSEQ_INIT);
    assign spl_iterate      = enable && !clear && (state_q == DCA_TSEQ_ADVANCE) && !spl_is_last_x;
    assign spl_go_next_base = enable && !clear && (state_q == DCA_TSEQ_ADVANCE) && spl_is_last_x;
    assign done             = enable && !clear && (state_q == DCA_TSEQ_DONE);

    assign req_fire = enable && lsu_req_valid && lsu_req_ready;

    always_comb begin
        state_d     = state_q;
        info_d      = info_q;
        col_first_d = col_first_q;
        inst_d      = inst_q;
        if (clear) begin
            state_d = DCA_TSEQ_IDLE;
        end else if (enable) begin
            case (state_q)
                DCA_TSEQ_IDLE: begin
                    if (cmd_valid) begin
                        info_d      = cmd_matrix_info;
                        col_first_d = cmd_is_col_first;
                        inst_d      = cmd_inst;
                        state_d     = DCA_TSEQ_INIT;
                    end
                end
                DCA_TSEQ_INIT: state_d = DCA_TSEQ_ISSUE;
                DCA_TSEQ_ISSUE: begin
                    if (req_fire) begin
                        state_d = spl_is_last_element ? DCA_TSEQ_DRAIN : DCA_TSEQ_ADVANCE;
                    end
                end
                DCA_TSEQ_ADVANCE: state_d = DCA_TSEQ_ISSUE;
                // Look at the next count so done follows the last completion by one cycle.
                DCA_TSEQ_DRAIN: begin
                    if (cnt_empty_next) begin
                        state_d = DCA_TSEQ_DONE;
                    end
                end
                DCA_TSEQ_DONE: state_d = DCA_TSEQ_IDLE;
                default:       state_d = DCA_TSEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q     <= DCA_TSEQ_IDLE;
            info_q      <= '0;
            col_first_q <= 1'b0;
            inst_q      <= '0;
        end else begin
            state_q     <= state_d;
            info_q      <= info_d;
            col_first_q <= col_first_d;
            inst_q      <= inst_d;
        end
    end

    always @(posedge clk) begin
        if (rstnn && enable && !clear) begin
            assert (MATRIX_NUM_ROW > 0 && MATRIX_NUM_COL > 0 && MAX_OUTSTANDING >= 1);
            assert (state_q != DCA_TSEQ_IDLE || cnt_empty);
            assert (!(state_q == DCA_TSEQ_ISSUE && spl_is_last_element)
                    || (spl_is_last_x && spl_is_last_y));
        end
    end

endmodule

// File: tb/tb_dca_matrix_tile_sequencer.sv
// tb/tb_dca_matrix_tile_sequencer.sv - directed bench for the matrix tile sequencer
module tb_dca_matrix_tile_sequencer;
    import dca_matrix_tile_sequencer_pkg::*;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_matrix_info = '0;
    logic        cmd_is_col_first = 1'b0;
    logic [3:0]  cmd_inst = '0;
    logic [31:0] spl_matrix_info;
    logic        spl_is_col_first, spl_init, spl_iterate, spl_go_next_base;
    logic        spl_is_last_x, spl_is_last_y, spl_is_last_element;
    logic [31:0] spl_block_info;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b1;
    logic [3:0]  lsu_req_inst;
    logic [31:0] lsu_req_info;
    logic        lsu_done = 1'b0;
    logic        busy, done;

    always #5 clk = ~clk;

    dca_matrix_tile_sequencer #(
        .MATRIX_SIZE_PARA (8),
        .MAX_OUTSTANDING  (MAXO),
        .BW_INST          (4)
    ) dut (
        .clk                 (clk),
        .rstnn               (rstnn),
        .clear               (clear),
        .enable              (enable),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_matrix_info     (cmd_matrix_info),
        .cmd_is_col_first    (cmd_is_col_first),
        .cmd_inst            (cmd_inst),
        .spl_matrix_info     (spl_matrix_info),
        .spl_is_col_first    (spl_is_col_first),
        .spl_init            (spl_init),
        .spl_iterate         (spl_iterate),
        .spl_go_next_base    (spl_go_next_base),
        .spl_is_last_x       (spl_is_last_x),
        .spl_is_last_y       (spl_is_last_y),
        .spl_is_last_element (spl_is_last_element),
        .spl_block_info      (spl_block_info),
        .lsu_req_valid       (lsu_req_valid),
        .lsu_req_ready       (lsu_req_ready),
        .lsu_req_inst        (lsu_req_inst),
        .lsu_req_info        (lsu_req_info),
        .lsu_done            (lsu_done),
        .busy                (busy),
        .done                (done)
    );

    // Splitter model: x walks the inner direction, y the outer one.
    int sx = 0;
    int sy = 0;
    dca_matrix_info_t mi, bi;
    int nbr, nbc, nx, ny, br, bc;

    always @(posedge clk) begin
        if (spl_init) begin
            sx <= 0;
            sy <= 0;
        end else if (spl_iterate) begin
            sx <= sx + 1;
        end else if (spl_go_next_base) begin
            sx <= 0;
            sy <= sy + 1;
        end
    end

    always_comb begin
        mi  = spl_matrix_info;
        nbr = int'(mi.num_row_m1) / 8 + 1;
        nbc = int'(mi.num_col_m1) / 8 + 1;
        nx  = spl_is_col_first ? nbr : nbc;
        ny  = spl_is_col_first ? nbc : nbr;
        br  = spl_is_col_first ? sx : sy;
        bc  = spl_is_col_first ? sy : sx;
        bi  = '0;
        bi.addr       = 16'(int'(mi.addr) + br * nbc + bc);
        bi.num_row_m1 = 8'((br == nbr - 1) ? int'(mi.num_row_m1) - 8 * br : 7);
        bi.num_col_m1 = 8'((bc == nbc - 1) ? int'(mi.num_col_m1) - 8 * bc : 7);
    end

    assign spl_block_info      = bi;
    assign spl_is_last_x       = (sx == nx - 1);
    assign spl_is_last_y       = (sy == ny - 1);
    assign spl_is_last_element = spl_is_last_x && spl_is_last_y;

    // LSU model and monitor; the LSU shares the sequencer's enable.
    logic [31:0] req_log[$];
    int due_q[$];
    int gnb_log[$];
    int cyc = 0;
    int lsu_lat = 0;
    bit hold = 1'b0;
    int force_n = 0;
    int done_cnt = 0, done_cyc = 0, last_ldone_cyc = 0, acc_cyc = 0;
    int both_err = 0, strobe_off_err = 0;

    always @(posedge clk) begin
        if (enable) begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (lsu_req_valid && lsu_req_ready) begin
                req_log.push_back(lsu_req_info);
                due_q.push_back(cyc + lsu_lat);
            end
            if (lsu_done) last_ldone_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (spl_go_next_base) gnb_log.push_back(req_log.size());
            if (spl_iterate && spl_go_next_base) both_err++;
            if (due_q.size() > 0 && (force_n > 0 || (!hold && due_q[0] <= cyc))) begin
                lsu_done <= 1'b1;
                void'(due_q.pop_front());
                if (force_n > 0) force_n--;
            end else begin
                lsu_done <= 1'b0;
            end
        end else if (spl_init || spl_iterate || spl_go_next_base || done) begin
            strobe_off_err++;
        end
        cyc++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        gnb_log.delete();
        done_cnt       = 0;
        both_err       = 0;
        strobe_off_err = 0;
    endtask

    task automatic start_cmd(input logic [31:0] info, input logic cf, input logic [3:0] inst);
        @(negedge clk);
        cmd_matrix_info  = info;
        cmd_is_col_first = cf;
        cmd_inst         = inst;
        cmd_valid        = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tick(2);
        check({tag, " done_pulses"}, done_cnt, 1);
    endtask

    // 16x24 matrix, 8x8 tiles: six full blocks, 3 block columns.
    task automatic check_addrs(input string tag, input int base, input bit cf);
        int idx;
        check({tag, " req_count"}, req_log.size(), 6);
        for (int i = 0; i < req_log.size() && i < 6; i++) begin
            idx = cf ? ((i % 2) * 3 + i / 2) : i;
            check($sformatf("%s req[%0d]", tag, i), req_log[i], {16'(base + idx), 8'd7, 8'd7});
        end
    endtask

    initial begin
        bit found;
        int n;

        // Reset
        tick(3);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst lsu_req_valid", lsu_req_valid, 0);
        check("rst done", done, 0);
        check("rst spl_init", spl_init, 0);
        check("rst spl_matrix_info", spl_matrix_info, 0);
        rstnn = 1'b1;
        tick(2);

        // Row-first 16x24
        clear_logs();
        start_cmd({16'h0100, 8'd15, 8'd23}, 1'b0, 4'h5);
        wait_done("row", 200);
        check_addrs("row", 'h100, 1'b0);
        check("row gnb_count", gnb_log.size(), 1);
        check("row gnb_after", (gnb_log.size() > 0) ? gnb_log[0] : -1, 3);
        check("row done_latency", done_cyc - last_ldone_cyc, 1);
        check("row both_strobes", both_err, 0);
        check("row inst", lsu_req_inst, 4'h5);
        check("row idle cmd_ready", cmd_ready, 1);
        check("row idle busy", busy, 0);

        // Column-first 16x24
        clear_logs();
        start_cmd({16'h0200, 8'd15, 8'd23}, 1'b1, 4'hA);
        wait_done("col", 200);
        check_addrs("col", 'h200, 1'b1);
        check("col gnb_count", gnb_log.size(), 2);
        check("col gnb_after", (gnb_log.size() > 0) ? gnb_log[0] : -1, 2);
        check("col both_strobes", both_err, 0);
        check("col inst", lsu_req_inst, 4'hA);

        // Single-block 5x5
        clear_logs();
        start_cmd({16'h0300, 8'd4, 8'd4}, 1'b0, 4'h1);
        wait_done("single", 50);
        check("single req_count", req_log.size(), 1);
        check("single req_info", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF,
              {16'h0300, 8'd4, 8'd4});
        check("single done_within_6", (done_cyc - acc_cyc) <= 6, 1);

        // Outstanding cap with completions withheld
        clear_logs();
        hold = 1'b1;
        start_cmd({16'h0400, 8'd15, 8'd23}, 1'b0, 4'h3);
        tick(12);
        check("cap req_count", req_log.size(), MAXO);
        check("cap lsu_req_valid", lsu_req_valid, 0);
        check("cap outstanding", 32'(dut.u_outstanding.count_q), MAXO);
        force_n = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (lsu_req_valid && lsu_req_ready && lsu_done && dut.u_outstanding.count_q == 1) found = 1'b1;
        end
        check("cap accept_and_done_seen", found, 1);
        @(negedge clk);
        check("cap count_stays_1", 32'(dut.u_outstanding.count_q), 1);
        hold = 1'b0;
        wait_done("cap", 200);
        check_addrs("cap", 'h400, 1'b0);

        // Clear while issuing block 3
        clear_logs();
        start_cmd({16'h0500, 8'd15, 8'd23}, 1'b0, 4'h6);
        n = 0;
        while (!(req_log.size() == 2 && lsu_req_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("clr reached_block3", (req_log.size() == 2) && lsu_req_valid, 1);
        clear = 1'b1;
        lsu_req_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        lsu_req_ready = 1'b1;
        check("clr cmd_ready", cmd_ready, 1);
        check("clr busy", busy, 0);
        check("clr lsu_req_valid", lsu_req_valid, 0);
        check("clr outstanding", 32'(dut.u_outstanding.count_q), 0);
        tick(4);
        check("clr no_done", done_cnt, 0);
        clear_logs();
        start_cmd({16'h0500, 8'd15, 8'd23}, 1'b0, 4'h6);
        wait_done("clr restart", 200);
        check_addrs("clr restart", 'h500, 1'b0);

        // Enable low for 5 cycles mid-run
        clear_logs();
        start_cmd({16'h0600, 8'd15, 8'd23}, 1'b0, 4'h7);
        n = 0;
        while (req_log.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        tick(2);
        check("ena busy_held", busy, 1);
        tick(3);
        enable = 1'b1;
        wait_done("ena", 200);
        check_addrs("ena", 'h600, 1'b0);
        check("ena no_strobes_when_off", strobe_off_err, 0);
        check("ena both_strobes", both_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
